// File: rtl/ysyx_25070198_mem_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// State encoding and requester ownership.
package ysyx_25070198_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_25070198_rr_arb2.sv
// Two-way round-robin picker.
// grant[0] = IFU, grant[1] = LSU; one-hot or zero.
module ysyx_25070198_rr_arb2
    import ysyx_25070198_mem_pkg::*;
(
    input  logic       en,
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (ifu_valid && lsu_valid) begin
                grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
            end else begin
                grant = {lsu_valid, ifu_valid};
            end
        end
    end

endmodule

// File: rtl/ysyx_25070198_mem_arb.sv
// Shares one memory port between fetch and load/store.
// One outstanding transaction; response is registered then routed.
module ysyx_25070198_mem_arb
    import ysyx_25070198_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    state_e              state_q, state_d;
    owner_e              own_q, own_d;
    owner_e              last_q, last_d;
    owner_e              rown_q, rown_d;
    logic                rvld_q, rvld_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                arb_en;
    logic [1:0]          grant;

    // No accept during reset or while a response is being delivered
    assign arb_en = rst && (state_q == IDLE) && !rvld_q;

    ysyx_25070198_rr_arb2 u_rr (
        .en         (arb_en),
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        rown_d  = rown_q;
        rvld_d  = 1'b0;
        rdata_d = '0;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    state_d = ISSUE;
                    own_d   = OWN_IFU;
                    last_d  = OWN_IFU;
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (grant[1]) begin
                    state_d = ISSUE;
                    own_d   = OWN_LSU;
                    last_d  = OWN_LSU;
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                end
            end
            ISSUE: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    rvld_d  = 1'b1;
                    rown_d  = own_q;
                    // Store acks carry no data
                    if (!(own_q == OWN_LSU && wen_q)) begin
                        rdata_d = mem_resp_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= OWN_IFU;
            last_q  <= OWN_LSU;
            rown_q  <= OWN_IFU;
            rvld_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            rown_q  <= rown_d;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign ifu_req_ready  = grant[0];
    assign lsu_req_ready  = grant[1];
    assign mem_req_valid  = (state_q == ISSUE);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_valid = rvld_q && (rown_q == OWN_IFU);
    assign lsu_resp_valid = rvld_q && (rown_q == OWN_LSU);
    assign ifu_resp_rdata = ifu_resp_valid ? rdata_q : '0;
    assign lsu_resp_rdata = lsu_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter.
// Inputs driven on negedge, outputs sampled 1ns later.
module tb_ysyx_25070198_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_25070198_mem_arb dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_rdata (ifu_resp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 00", {ifu_req_ready, lsu_req_ready});
        end
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b exp 000",
                     {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        checks++;
        if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== 69'd0) begin
            errors++;
            $display("FAIL reset_payload: got %h %b %h %h exp zeros",
                     mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
        end
        checks++;
        if ({ifu_resp_rdata, lsu_resp_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h exp 0", ifu_resp_rdata, lsu_resp_rdata);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_ifu_fetch();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_accept: got %b exp 10", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        ifu_req_addr  = '0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL ifu_issue: got v=%b a=%h w=%b m=%h exp v=1 a=80000000 w=0 m=0",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0010_0073;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL ifu_wait: got %b exp 00", {mem_req_valid, ifu_resp_valid});
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid} !== {1'b1, 32'h0010_0073, 1'b0}) begin
            errors++;
            $display("FAIL ifu_resp: got v=%b d=%h lsu_v=%b exp v=1 d=00100073 lsu_v=0",
                     ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ifu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_pulse_width: got %b exp 0", ifu_resp_valid);
        end
    endtask

    task automatic test_lsu_store();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'hF;
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lsu_accept: got %b exp 01", {ifu_req_ready, lsu_req_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_req_ready = (i == 3);
            #1;
            checks++;
            if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask}
                !== {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
                errors++;
                $display("FAIL lsu_hold_%0d: got v=%b w=%b a=%h d=%h m=%h exp 1 1 80001000 deadbeef f",
                         i, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask);
            end
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsu_wait: mem_req_valid got %b exp 0", mem_req_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL lsu_store_ack: got v=%b d=%h ifu_v=%b exp v=1 d=0 ifu_v=0",
                     lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (lsu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsu_pulse_width: got %b exp 0", lsu_resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   grants[$];
        int   both  = 0;
        int   ifu_n = 0;
        int   lsu_n = 0;
        logic hs_prev = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            ifu_req_valid  = (c < 20);
            ifu_req_addr   = 32'h8000_0100;
            lsu_req_valid  = (c < 20);
            lsu_req_addr   = 32'h8000_3000;
            lsu_req_wen    = 1'b0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = hs_prev;
            mem_resp_rdata = 32'hA000_0000 + c;
            #1;
            if (ifu_req_ready && lsu_req_ready) both++;
            if (ifu_req_ready) grants.push_back(0);
            else if (lsu_req_ready) grants.push_back(1);
            if (ifu_resp_valid) ifu_n++;
            if (lsu_resp_valid) lsu_n++;
            hs_prev = mem_req_valid && mem_req_ready;
        end
        clear_inputs();
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL b2b_both_ready: got %0d cycles exp 0", both);
        end
        checks++;
        if (grants.size() !== 5) begin
            errors++;
            $display("FAIL b2b_grant_count: got %0d exp 5", grants.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grants.size()) begin
                errors++;
                $display("FAIL b2b_order_%0d: got none exp %0d", i, i % 2);
            end else if (grants[i] !== i % 2) begin
                errors++;
                $display("FAIL b2b_order_%0d: got %0d exp %0d", i, grants[i], i % 2);
            end
        end
        checks++;
        if ({ifu_n, lsu_n} !== {32'd3, 32'd2}) begin
            errors++;
            $display("FAIL b2b_resp_route: got ifu=%0d lsu=%0d exp ifu=3 lsu=2", ifu_n, lsu_n);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_4000;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_accept: got %b exp 1", lsu_req_ready);
        end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_issue: got %b exp 1", mem_req_valid);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h55AA_55AA;
        #1;
        checks++;
        if ({mem_req_valid, lsu_resp_valid, ifu_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_after_rst: got %b exp 000",
                     {mem_req_valid, lsu_resp_valid, ifu_resp_valid});
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({lsu_resp_valid, ifu_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_late_resp: got %b exp 00", {lsu_resp_valid, ifu_resp_valid});
        end
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_next_accept: got %b exp 1", ifu_req_ready);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0004}) begin
            errors++;
            $display("FAIL rmid_next_issue: got v=%b a=%h exp v=1 a=80000004",
                     mem_req_valid, mem_req_addr);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0013;
        #1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid} !== {1'b1, 32'h13, 1'b0}) begin
            errors++;
            $display("FAIL rmid_next_resp: got v=%b d=%h lsu_v=%b exp v=1 d=00000013 lsu_v=0",
                     ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid);
        end
        clear_inputs();
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_DEAD;
        #1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL spur_idle: got %b exp 00", {ifu_resp_valid, lsu_resp_valid});
        end
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL spur_accept: got %b exp 01", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL spur_issue: got %b exp 1", mem_req_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL spur_in_issue: got %b exp 100",
                     {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        #1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            errors++;
            $display("FAIL spur_real_resp: got v=%b d=%h ifu_v=%b exp v=1 d=cafef00d ifu_v=0",
                     lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_ifu_fetch();
        test_lsu_store();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25070198_mem_arb.md
# ysyx_25070198_mem_arb

Two-requester memory arbiter sharing one memory port between instruction fetch (IFU) and load/store (LSU). It sits between the core and the single memory model port and replaces the separate fetch and data DPI reads with one handshaked path. Round-robin arbitration, one outstanding transaction, and a registered response routed to the owning requester.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width; wmask width is DATA_W/8

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_resp_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted this cycle
- lsu_req_addr  in  ADDR_W  data address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
- lsu_resp_rdata  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wen  out  1  latched write enable (0 for IFU)
- mem_req_wdata  out  DATA_W  latched write data (0 for IFU)
- mem_req_wmask  out  DATA_W/8  latched mask (0 for IFU)
- mem_resp_valid  in  1  memory response
- mem_resp_rdata  in  DATA_W  memory read data

## Operation
- FSM: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid, pick winner, assert winner's req_ready combinationally, latch payload and owner, go ISSUE. Loser's ready stays 0. Both ready never 1 together.
- Arbitration: only one valid -> it wins. Both valid -> the one not granted last. last_grant resets to LSU, so the first tie goes to IFU.
- ISSUE: mem_req_valid=1 with latched payload, held stable until mem_req_ready; on handshake go WAIT.
- WAIT: on mem_resp_valid, register data; next cycle pulse owner's resp_valid with rdata (LSU store: rdata=0); go IDLE in the same cycle as mem_resp_valid.
- mem_resp_valid in IDLE or ISSUE: ignored.
- req_ready is 0 outside IDLE, and also 0 in the cycle a response is being delivered.
- Requesters must accept responses; no response backpressure.

## Timing
- Reset values: all req_ready, resp_valid, mem_req_valid = 0; all data/addr/mask outputs = 0; state IDLE; last_grant = LSU.
- Reset mid-transaction: abort, drop owner, no response pulse; a late mem_resp_valid after reset is ignored.
- Minimum latency: accept at T, mem_req_valid at T+1, response at T+2 (if ready at T+1), resp_valid at T+3.
- Next accept is at earliest the cycle after resp_valid (T+4). Throughput is 1 transaction per 4 cycles minimum.
- mem_req_* outputs are registers; req_ready is combinational from state and req_valid.

## Structure
- Package ysyx_25070198_mem_pkg holds the state enum (IDLE/ISSUE/WAIT) and the owner encoding (OWN_IFU=0, OWN_LSU=1).
- Sub-module ysyx_25070198_rr_arb2: 2-way round-robin picker (inputs: two valids, last_grant, enable; outputs: one-hot grant).

## Test plan
- Only IFU requests addr 0x80000000; memory ready immediately and returns 0x00100073 next cycle -> ifu_ready at T, mem_req_valid at T+1, ifu_resp_valid at T+3 with 0x00100073; lsu_resp_valid stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready held low 3 cycles -> mem_req payload stable all cycles; one lsu_resp_valid pulse with rdata 0.
- Both valid continuously after reset -> grants alternate IFU, LSU, IFU, LSU; never both ready in one cycle.
- rst=0 asserted while in WAIT, then mem_resp_valid arrives -> no resp_valid pulse; FSM returns to IDLE; next request completes normally.
- Spurious mem_resp_valid in IDLE and in ISSUE -> ignored; no resp_valid; the real response still routes to the correct owner.
